// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] i_r,
  input  logic          i_q_msb,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_r,
  output logic          o_q_bit
);

  logic [DW:0] w_r_shift;
  logic        w_ge;

  assign w_r_shift = {i_r, i_q_msb};
  assign w_ge      = (w_r_shift >= {1'b0, i_d});

  // The shifted value may reach 2^DW, but then it always exceeds the divisor,
  // so the restored result fits back into DW bits.
  always_comb begin
    // NOTE: default every output first so no path leaves one unassigned (no latch).
    o_r     = w_r_shift[DW-1:0];
    o_q_bit = 1'b0;
    if (w_ge) begin
      o_r     = DW'(w_r_shift - {1'b0, i_d});
      o_q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock under a
// start/busy/done handshake; a zero divisor short-circuits to a flagged result.
module seq_divider
  import div_pkg::*;
#(
  parameter  int DW = DW_DEFAULT,
  localparam int CW = $clog2(DW) + 1
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  div_state_t    r_state;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_r;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quotient;
  logic [DW-1:0] r_remainder;
  logic          r_dbz;

  logic [DW-1:0] w_r_next;
  logic          w_q_bit;
  logic [DW-1:0] w_q_next;

  // The partial remainder is always below the divisor after a step, so its
  // extra top bit is only ever needed inside the step's compare.
  div_step #(.DW(DW)) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[DW-1]),
    .i_d     (r_d),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  assign w_q_next = {r_q[DW-2:0], w_q_bit};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_q     <= bus.dividend;
            r_d     <= bus.divisor;
            r_r     <= '0;
            r_count <= '0;
            if (bus.divisor != '0) begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
            end
          end
        end

        CALC: begin
          r_r     <= w_r_next;
          r_q     <= w_q_next;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(DW - 1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_dbz       <= 1'b0;
          end
        end

        DONE: begin
          // A zero divisor arrives here with done still low; publish its
          // result one edge later so done follows the accepting edge by one.
          if (!r_done) begin
            r_done      <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= r_q;
            r_dbz       <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic
// reference (integer / and %), plus directed boundary and handshake cases.
module tb_seq_divider;
  import div_pkg::*;

  localparam int DW    = DW_DEFAULT;
  localparam int N_RND = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_divider_if #(.DW(DW)) bus ();

  seq_divider #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned division with the zero-divisor convention.
  task automatic model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q  = (1 << DW) - 1;
      r  = a;
      dz = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 0;
    end
  endtask

  // One division with a single-cycle start pulse; checks latency and results.
  task automatic run_one(input int a, input int b, input string tag);
    int q, r, dz, lat;
    bit seen;
    model(a, b, q, r, dz);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = DW'(a);
    bus.divisor  = DW'(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = DW'($urandom);
    check({tag, "_busy"}, bus.busy, (b != 0));
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 4 * DW; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      lat++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, (b == 0) ? 1 : DW);
    check({tag, "_quotient"}, bus.quotient, q);
    check({tag, "_remainder"}, bus.remainder, r);
    check({tag, "_dbz"}, bus.div_by_zero, dz);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_done, a, b, q, r, dz, cyc;
    int oq, or_;
    bit seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases and boundaries
    run_one(100, 7, "d100_7");
    run_one(255, 1, "d255_1");
    run_one(5, 9, "d5_9");
    run_one(255, 255, "d255_255");
    run_one(0, 3, "d0_3");
    run_one(77, 0, "d77_0");
    run_one(9, 3, "d9_3");

    // Start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd10; bus.divisor = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0; oq = 0; or_ = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        n_done++;
        oq  = bus.quotient;
        or_ = bus.remainder;
      end
      @(negedge clk);
    end
    check("coll_done_count", n_done, 1);
    check("coll_quotient", oq, 22);
    check("coll_remainder", or_, 2);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_quotient", bus.quotient, 0);
    check("mid_rst_remainder", bus.remainder, 0);
    check("mid_rst_dbz", bus.div_by_zero, 0);
    check("mid_rst_state", dut.r_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    check("mid_rst_no_done", n_done, 0);
    run_one(50, 6, "d50_6");

    // Random back-to-back with start held high
    @(negedge clk);
    a = $urandom_range(0, (1 << DW) - 1);
    b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(1, (1 << DW) - 1);
    bus.dividend = DW'(a);
    bus.divisor  = DW'(b);
    bus.start    = 1'b1;
    for (int k = 0; k < N_RND; k++) begin
      cyc  = 0;
      seen = 0;
      for (int i = 0; i < 4 * DW; i++) begin
        if (bus.done) begin
          seen = 1;
          break;
        end
        @(negedge clk);
        cyc++;
      end
      check("rnd_done_seen", seen, 1);
      if (!seen) break;
      if (k > 0) check("rnd_period", cyc + 1, DW + 2);
      model(a, b, q, r, dz);
      oq  = bus.quotient;
      or_ = bus.remainder;
      check("rnd_quotient", oq, q);
      check("rnd_remainder", or_, r);
      check("rnd_dbz", bus.div_by_zero, dz);
      check("rnd_invariant", oq * b + or_, a);
      check("rnd_rem_lt_div", (or_ < b), 1);
      if (k == N_RND - 1) begin
        bus.start = 1'b0;
      end else begin
        a = $urandom_range(0, (1 << DW) - 1);
        b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(1, (1 << DW) - 1);
        bus.dividend = DW'(a);
        bus.divisor  = DW'(b);
      end
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's shift-add multiplier.
- Takes an unsigned DW-bit dividend and divisor and produces the quotient and remainder.
- Produces one quotient bit per clock, shift-subtract style, under a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath and is driven by the same controller.

Parameters:
- DW, 8, operand, quotient and remainder width (must be ≥ 2).
- CW, $clog2(DW)+1, step-counter width (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  DW  unsigned dividend; captured on the accepting edge.
- divisor  input  DW  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  DW  registered quotient; holds until the next done.
- remainder  output  DW  registered remainder; holds until the next done.
- div_by_zero  output  1  registered flag; updated with each done.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; busy, done, div_by_zero, quotient, remainder = 0.
  - Internal registers and counter = 0.
  - Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a clk edge with start=1 (edge E0), latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (DW+1 bits) and count.
  - If divisor != 0, go to CALC and set busy=1.
  - If divisor == 0, go to DONE directly.
- CALC, one step per edge E1..E(DW):
  - R' = {R[DW-1:0], Q[DW-1]}.
  - If R' >= {1'b0, D}: R = R' - D and Q = {Q[DW-2:0], 1}.
  - Otherwise: R = R' and Q = {Q[DW-2:0], 0}.
  - count increments each step.
  - At the step where count == DW-1, go to DONE.
- DONE (one cycle):
  - On the edge entering DONE, load quotient = Q and remainder = R[DW-1:0], and set done=1 and busy=0.
  - For a normal division, done is high in the cycle after edge E(DW).
  - Next edge: done=0, state = IDLE.
- Latency: start accepted at E0; done high after E(DW) (DW cycles). For a zero divisor, done is high after E1.
- Divide by zero:
  - quotient = all ones; remainder = dividend; div_by_zero = 1.
  - No CALC cycles are executed.
- div_by_zero is cleared to 0 on every non-zero-divisor done.
- start while in CALC or DONE is ignored. Operands are not re-sampled, and no result is corrupted.
- start held high continuously begins a new division on the first IDLE edge after DONE. The back-to-back period is DW+2 cycles.
- Inputs are don't-care except on the accepting edge.
- Arithmetic rules:
  - R is DW+1 bits so the compare never overflows.
  - All arithmetic is unsigned.
  - Invariant at done: dividend == quotient*divisor + remainder, and remainder < divisor.
- quotient, remainder and div_by_zero are never modified outside the DONE-entry edge.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  - localparam DW_DEFAULT = 8.
- One natural sub-module: div_step. It is combinational, with parameter DW.
  - Inputs: R, Q msb, D.
  - Outputs: next R and the quotient bit.
- The top level holds the FSM, counter, registers and handshake.

Test Plan:
- 100/7: dividend=100, divisor=7, start one cycle -> busy for 8 cycles; done after E8; quotient=14, remainder=2, div_by_zero=0.
- Boundaries:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
  - 0/3 -> quotient=0, remainder=0.
- Zero divisor: 77/0 -> done after E1; quotient=8'hFF, remainder=77, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Busy collision: start 200/9, then pulse start with 10/2 at E3 -> result quotient=22, remainder=2; exactly one done; no second done.
- Reset mid-op: rst low at E4 of 100/7 -> all outputs 0, state IDLE, no done. Next 50/6 -> quotient=8, remainder=2.
- Random: 1000 random pairs (divisor ≠ 0) with start held high -> invariant holds every done; done period = DW+2 cycles.
